// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: small sample FIFO that feeds a FIR filter at a fixed
// programmable rate. After enable it waits for the FIFO to prime, then it
// issues one accumulate strobe every (period+1) clocks. A strobe that finds
// the FIFO empty sends a zero sample and sets a sticky underrun flag.
module fir_sample_feeder #(
  parameter int DEPTH     = 4,  // FIFO entries, power of two, 2..16
  parameter int PRIME_LVL = 2   // FIFO level needed before the first strobe
) (
  input  logic                       iClk_12M,
  input  logic                       iRsn,
  input  logic                       iEnable,
  input  logic [7:0]                 iPeriod,
  input  logic                       iInValid,
  input  logic [2:0]                 iInData,
  output logic                       oInReady,
  input  logic                       iClrUnderrun,
  output logic                       oEnAcc,
  output logic [2:0]                 oFirIn,
  output logic                       oUnderrun,
  output logic [$clog2(DEPTH):0]     oLevel
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [7:0]      cnt_q, per_q;
  logic [2:0]      mem [DEPTH];

  logic            strobe;
  logic            run_entry;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // Flow control is decoded from the registered level only, so a pop on the
  // same edge never frees a slot for a push while full.
  assign oInReady   = (level_q != LW'(DEPTH));
  assign oLevel     = level_q;
  assign fifo_empty = (level_q == '0);
  assign push       = iInValid && oInReady;
  assign pop        = strobe && !fifo_empty;

  // Next-state decode plus the strobe decision and RUN-entry event.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path through the case can infer a latch.
    state_d   = state_q;
    strobe    = 1'b0;
    run_entry = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iEnable) state_d = PRIME;
      end
      PRIME: begin
        if (!iEnable) begin
          state_d = IDLE;
        end else if (level_q >= LW'(PRIME_LVL)) begin
          state_d   = RUN;
          run_entry = 1'b1;
        end
      end
      RUN: begin
        // The strobe decision ignores iEnable, so a strobe due on the cycle
        // enable drops is still issued.
        strobe = (cnt_q == per_q);
        if (!iEnable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, FIFO pointers/level, rate counter and output registers.
  always_ff @(posedge iClk_12M) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!iRsn) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      per_q     <= '0;
      oEnAcc    <= 1'b0;
      oFirIn    <= '0;
      oUnderrun <= 1'b0;
    end else begin
      state_q <= state_d;

      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase

      // The period register re-latches at every interval boundary, so a
      // mid-run period change applies from the next interval.
      if (run_entry || strobe) begin
        cnt_q <= '0;
        per_q <= iPeriod;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + 8'd1;
      end

      oEnAcc <= strobe;
      if (strobe) oFirIn <= fifo_empty ? 3'd0 : mem[rd_ptr_q];

      // Set has priority over clear.
      if (strobe && fifo_empty) begin
        oUnderrun <= 1'b1;
      end else if (iClrUnderrun) begin
        oUnderrun <= 1'b0;
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge iClk_12M) begin
    // NOTE: the storage array has no reset; the pointers and level define which entries are valid.
    if (iRsn && push) mem[wr_ptr_q] <= iInData;
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder (DEPTH=4, PRIME_LVL=2). Inputs change
// 1 ns after a rising edge; outputs are checked at the same point, so each
// check sees the registers updated by the edge just taken.
module tb_fir_sample_feeder;

  logic       iClk_12M = 1'b0;
  logic       iRsn;
  logic       iEnable;
  logic [7:0] iPeriod;
  logic       iInValid;
  logic [2:0] iInData;
  logic       oInReady;
  logic       iClrUnderrun;
  logic       oEnAcc;
  logic [2:0] oFirIn;
  logic       oUnderrun;
  logic [2:0] oLevel;

  int n_checks = 0;
  int n_errors = 0;

  fir_sample_feeder #(.DEPTH(4), .PRIME_LVL(2)) dut (
    .iClk_12M     (iClk_12M),
    .iRsn         (iRsn),
    .iEnable      (iEnable),
    .iPeriod      (iPeriod),
    .iInValid     (iInValid),
    .iInData      (iInData),
    .oInReady     (oInReady),
    .iClrUnderrun (iClrUnderrun),
    .oEnAcc       (oEnAcc),
    .oFirIn       (oFirIn),
    .oUnderrun    (oUnderrun),
    .oLevel       (oLevel)
  );

  always #5 iClk_12M = ~iClk_12M;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk_12M);
    #1;
  endtask

  function automatic int fir();
    return int'($signed(oFirIn));
  endfunction

  task automatic push(input int d);
    iInValid = 1'b1;
    iInData  = 3'(d);
    tick();
    iInValid = 1'b0;
  endtask

  // Ticks until oEnAcc is seen high; returns the tick count, or 0 if the
  // limit expires first.
  task automatic wait_strobe(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (oEnAcc) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_strobes(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (oEnAcc) n++;
    end
  endtask

  int n;
  int v[9] = '{-1, -2, -3, -4, 3, 2, 1, 0, -1};
  int exp_out;

  initial begin
    iRsn = 1'b0; iEnable = 1'b0; iPeriod = 8'd3;
    iInValid = 1'b1; iInData = 3'd3; iClrUnderrun = 1'b0;

    // Reset state; a push attempt during reset must be ignored.
    tick(); tick();
    check("rst_level", oLevel, 0);
    check("rst_ready", oInReady, 1);
    check("rst_enacc", oEnAcc, 0);
    check("rst_firin", fir(), 0);
    check("rst_underrun", oUnderrun, 0);
    iInValid = 1'b0;
    iRsn = 1'b1;
    tick();
    check("rst_push_ignored", oLevel, 0);

    // Basic run: +1, -2, +3, then an underrun, period 3.
    push(1); push(-2); push(3);
    check("basic_level", oLevel, 3);
    iEnable = 1'b1;
    wait_strobe(20, n);
    check("first_strobe_delay", n, 6);
    check("s1_data", fir(), 1);
    check("s1_level", oLevel, 2);
    tick();
    check("s1_pulse_one_cycle", oEnAcc, 0);
    check("s1_data_held", fir(), 1);
    wait_strobe(20, n);
    check("s2_gap", n + 1, 4);
    check("s2_data", fir(), -2);
    wait_strobe(20, n);
    check("s3_gap", n, 4);
    check("s3_data", fir(), 3);
    check("s3_no_underrun", oUnderrun, 0);
    check("s3_level", oLevel, 0);
    wait_strobe(20, n);
    check("s4_gap", n, 4);
    check("s4_zero_stuff", fir(), 0);
    check("s4_underrun", oUnderrun, 1);

    // Underrun clear, set/clear collision, enable drop on a strobe cycle.
    iClrUnderrun = 1'b1; tick();
    check("clr_underrun", oUnderrun, 0);
    iClrUnderrun = 1'b0; tick(); tick();
    iClrUnderrun = 1'b1; tick();
    check("collide_strobe", oEnAcc, 1);
    check("collide_set_wins", oUnderrun, 1);
    tick();
    check("clr_later", oUnderrun, 0);
    iClrUnderrun = 1'b0; tick(); tick();
    iEnable = 1'b0; tick();
    check("drop_enable_strobe", oEnAcc, 1);
    count_strobes(12, n);
    check("after_disable_strobes", n, 0);
    iClrUnderrun = 1'b1; tick(); iClrUnderrun = 1'b0;
    check("idle_underrun_clr", oUnderrun, 0);

    // Fill while idle: five offered, four accepted.
    iInValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iInData = 3'(i);
      tick();
      if (i == 3) begin
        check("full_ready", oInReady, 0);
        check("full_level4", oLevel, 4);
      end
    end
    check("full_5th_rejected", oLevel, 4);
    iInValid = 1'b0;

    // Period 0 with continuous push: strobe every clock, order preserved.
    iPeriod = 8'd0; iEnable = 1'b1;
    tick(); tick();
    for (int k = 1; k <= 10; k++) begin
      iInValid = 1'b1;
      iInData  = 3'((k == 1) ? v[0] : v[k-2]);
      tick();
      exp_out = (k <= 4) ? (k - 1) : v[k-5];
      check($sformatf("p0_enacc_%0d", k), oEnAcc, 1);
      check($sformatf("p0_data_%0d", k), fir(), exp_out);
      check($sformatf("p0_level_%0d", k), oLevel, 3);
      check($sformatf("p0_underrun_%0d", k), oUnderrun, 0);
    end
    iInValid = 1'b0; iEnable = 1'b0;
    tick();
    check("p0_last_data", fir(), 1);
    check("p0_last_level", oLevel, 2);

    // Period change 3 -> 7 mid-interval. FIFO holds 0, -1, then 1, 2.
    iPeriod = 8'd3;
    push(1); push(2);
    iEnable = 1'b1;
    wait_strobe(20, n);
    check("pc_first_delay", n, 6);
    check("pc_first_data", fir(), 0);
    tick(); tick();
    iPeriod = 8'd7;
    wait_strobe(20, n);
    check("pc_current_interval", n + 2, 4);
    check("pc_data2", fir(), -1);
    wait_strobe(20, n);
    check("pc_next_interval", n, 8);
    check("pc_data3", fir(), 1);
    wait_strobe(20, n);
    check("pc_later_interval", n, 8);
    check("pc_data4", fir(), 2);

    // Reset mid-RUN with level 3.
    push(-4); push(-3); push(-2);
    check("mr_level", oLevel, 3);
    iRsn = 1'b0; tick(); iRsn = 1'b1;
    check("mr_level0", oLevel, 0);
    check("mr_enacc0", oEnAcc, 0);
    check("mr_firin0", fir(), 0);
    check("mr_underrun0", oUnderrun, 0);
    count_strobes(12, n);
    check("mr_no_strobe_empty", n, 0);
    check("mr_no_underrun", oUnderrun, 0);
    push(3);
    count_strobes(12, n);
    check("mr_no_strobe_one", n, 0);
    push(-3);
    wait_strobe(20, n);
    check("mr_reprime_delay", n, 9);
    check("mr_reprime_data", fir(), 3);
    check("mr_reprime_level", oLevel, 1);

    iEnable = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
